out_signature_monitor: RTL and testbench
========================================

# out_signature_monitor

Synthesizable response-side companion to the randomized stimulus bench. It samples the DUT's wide flat output bus on qualified cycles and compresses it into a 32-bit MISR signature over a fixed window of samples. The finished signature is presented on a valid/ready port, so two simulators, or a simulator and an emulator, can compare one word per window instead of full per-cycle traces. It sits beside the DUT in the top harness and observes `out_flat`.

## Interface
- `OUT_W`, 159: width of observed bus, 1..1024.
- `WINDOW`, 150: samples per signature, 1..65535.
- `SEED`, 32'hFFFF_FFFF: MISR value loaded on start.
- `POLY`, 32'h04C1_1DB7: MISR feedback polynomial.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a window.
- `sample_en` in 1: qualifies `data_in` this cycle.
- `data_in` in OUT_W: observed DUT output (`out_flat`).
- `sig_ready` in 1: consumer accepts signature.
- `sig_valid` out 1: signature available.
- `sig_data` out 32: MISR signature.
- `sig_count` out 16: samples folded in the current or held window.
- `sig_cycles` out 16: clocks spent in ACCUM, saturating at 16'hFFFF.
- `busy` out 1: state is not IDLE.
- `overrun` out 1: sticky; sample_en asserted while in HOLD.

## Operation
- States: IDLE, ACCUM, HOLD.
  - IDLE: `start` loads `sig_data`=SEED, clears `sig_count`, `sig_cycles` and `overrun`, then moves to ACCUM. `sample_en` is ignored in IDLE.
  - ACCUM: each cycle `sig_cycles`++ (saturating). On `sample_en` the MISR updates and `sig_count`++. When the update makes `sig_count`==WINDOW, move to HOLD.
  - HOLD: `sig_valid`=1. `sig_data`, `sig_count` and `sig_cycles` are frozen. `sig_valid && sig_ready` moves to IDLE.
- `start` in ACCUM or HOLD is ignored; it has no effect on state or registers.
- Fold: `data_in` is split into K=ceil(OUT_W/32) slices of 32 bits, with slice k = bits [32k+31:32k]. Bits at or above OUT_W read as 0. `fold` = XOR of all slices. For OUT_W=159, K=5 and the top slice holds 31 live bits.
- MISR update: `sig_next` = ({sig[30:0],1'b0} ^ (sig[31] ? POLY : 0)) ^ fold.
- `sample_en` in HOLD drops the sample and sets `overrun`. `overrun` stays set through IDLE and is cleared only by the next accepted `start`.
- Outputs after returning to IDLE:
  - `sig_data`, `sig_count` and `sig_cycles` keep their last values until the next `start`.
  - `sig_valid`=0.
  - `busy`=0.

## Timing
- Reset values, applied asynchronously:
  - state IDLE
  - `sig_valid`=0, `sig_data`=SEED
  - `sig_count`=0, `sig_cycles`=0
  - `busy`=0, `overrun`=0
- Reset deasserts synchronously to `clk` through the flop reset path. No clocked action occurs on the edge where `rst` is high.
- `start` sampled at edge N:
  - At N, ACCUM is entered and `busy` rises.
  - The first sample that can be folded is at edge N+1. A same-cycle `sample_en` with `start` is not folded.
- The WINDOW-th sample, folded at edge M:
  - At M, `sig_valid` rises and `sig_data` carries the final value.
  - Latency from last sample to valid is 1 clock, with no combinational path from `data_in` to outputs.
- Handshake:
  - `sig_valid` holds until it is accepted.
  - Acceptance at edge A drops `sig_valid` and `busy` at A.
  - `start` at A+1 is legal.
  - `start` at A is ignored, because the state is HOLD on that edge.
- WINDOW=1: HOLD is entered on the first sampled cycle.
- `sig_cycles` counts the edge that enters HOLD. For WINDOW consecutive samples it equals WINDOW.
- Reset in mid-ACCUM or mid-HOLD aborts immediately. Any pending signature is lost, and `overrun` is cleared.

## Test plan
- **Zero data:** SEED=0, WINDOW=1, start, then sample `data_in`=0 -> `sig_valid`=1 one clock later, `sig_data`=0, `sig_count`=1, `sig_cycles`=1.
- **Feedback and fold cancellation:** WINDOW=1.
  - SEED=32'h8000_0000 with `data_in`=0 -> `sig_data`=32'h04C1_1DB7.
  - SEED=0 with `data_in` bits 0 and 32 set -> `sig_data`=0.
  - SEED=0 with only bit 158 set -> `sig_data`=32'h4000_0000.
- **Gapped sampling:** WINDOW=4, `sample_en` pattern 1,0,1,1,0,1 -> HOLD entered on the 6th ACCUM edge, `sig_count`=4, `sig_cycles`=6.
- **Backpressure:** in HOLD, `sig_ready`=0 for 5 clocks with `sample_en`=1 and a `start` pulse.
  - During the stall: `sig_data` is unchanged, `overrun`=1 and state stays HOLD.
  - `sig_ready`=1 -> IDLE next edge, and `overrun` is still 1.
  - A new `start` clears `overrun`.
- **Cross-check vs bench:** default parameters, 150 LCG cycles sampled every cycle from seed 3199895932 -> `sig_data` matches the bench's reference-model MISR computed on the printed OUT values.
- **Reset abort:** `rst` pulse after 3 of 150 samples -> all outputs return to reset values asynchronously, with no `sig_valid`. A new window then produces the same signature as a clean run.

Source files
------------

// File: rtl/out_signature_monitor.sv
// rtl/out_signature_monitor.sv - MISR signature monitor for a wide DUT output bus
//
// Purpose:
//   Folds qualified samples of a wide observed bus into a 32-bit MISR over a
//   window of WINDOW samples. The finished signature is offered on a
//   valid/ready port, so two runs can be compared one word per window.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   pulse that begins a window (honoured only in IDLE)
//   sample_en  in   qualifies data_in this cycle (folded only in ACCUM)
//   data_in    in   observed bus, OUT_W bits
//   sig_ready  in   consumer accepts the signature
//   sig_valid  out  signature available (state HOLD)
//   sig_data   out  MISR signature
//   sig_count  out  samples folded in the current or held window
//   sig_cycles out  clocks spent in ACCUM, saturating
//   busy       out  state is not IDLE
//   overrun    out  sticky, sample_en seen while in HOLD

module out_signature_monitor #(
   parameter int          OUT_W  = 159,
   parameter int          WINDOW = 150,
   parameter logic [31:0] SEED   = 32'hFFFF_FFFF,
   parameter logic [31:0] POLY   = 32'h04C1_1DB7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sample_en,
   input  logic [OUT_W-1:0] data_in,
   input  logic             sig_ready,
   output logic             sig_valid,
   output logic [31:0]      sig_data,
   output logic [15:0]      sig_count,
   output logic [15:0]      sig_cycles,
   output logic             busy,
   output logic             overrun
);

   localparam int          K   = (OUT_W + 31) / 32;
   localparam logic [15:0] WIN = 16'(WINDOW);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] sig_q, sig_d;
   logic [15:0] count_q, count_d;
   logic [15:0] cycles_q, cycles_d;
   logic        overrun_q, overrun_d;

   logic [K*32-1:0] padded;
   logic [31:0]     fold;
   logic [31:0]     sig_next;

   // Zero-extend the bus to whole 32-bit slices, then XOR the slices together.
   always_comb begin
      padded              = '0;
      padded[OUT_W-1:0]   = data_in;
      fold                = '0;
      for (int k = 0; k < K; k++) begin
         fold = fold ^ padded[32*k +: 32];
      end
   end

   assign sig_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;

   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      count_d   = count_q;
      cycles_d  = cycles_q;
      overrun_d = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sig_d     = SEED;
               count_d   = 16'd0;
               cycles_d  = 16'd0;
               overrun_d = 1'b0;
               state_d   = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            // The edge that enters HOLD is itself an ACCUM clock and is counted.
            if (cycles_q != 16'hFFFF) begin
               cycles_d = cycles_q + 16'd1;
            end
            if (sample_en) begin
               sig_d   = sig_next;
               count_d = count_q + 16'd1;
               if (count_q + 16'd1 == WIN) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // Samples arriving while the signature is unclaimed are lost; flag it.
            if (sample_en) begin
               overrun_d = 1'b1;
            end
            if (sig_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sig_q     <= SEED;
         count_q   <= 16'd0;
         cycles_q  <= 16'd0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_q     <= sig_d;
         count_q   <= count_d;
         cycles_q  <= cycles_d;
         overrun_q <= overrun_d;
      end
   end

   assign sig_valid  = (state_q == ST_HOLD);
   assign busy       = (state_q != ST_IDLE);
   assign sig_data   = sig_q;
   assign sig_count  = count_q;
   assign sig_cycles = cycles_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_out_signature_monitor.sv
// tb/tb_out_signature_monitor.sv - scoreboard bench for out_signature_monitor

module tb_out_signature_monitor;

   localparam logic [31:0] POLY_C   = 32'h04C1_1DB7;
   localparam logic [31:0] SEED_DEF = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sample_en;
   logic         sig_ready;
   logic [158:0] data_in;

   // Instance index: 0 defaults, 1 SEED=0 W=1, 2 SEED=8000_0000 W=1, 3 W=4
   logic [3:0]        valid_v, busy_v, ovr_v;
   logic [3:0][31:0]  data_v;
   logic [3:0][15:0]  cnt_v, cyc_v;

   int checks = 0;
   int errors = 0;
   logic [31:0] lcg_s;

   typedef struct {
      int          inst;
      logic [31:0] sig;
      logic [15:0] cnt;
      logic [15:0] cyc;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   out_signature_monitor u_def (
      .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .data_in(data_in),
      .sig_ready(sig_ready), .sig_valid(valid_v[0]), .sig_data(data_v[0]),
      .sig_count(cnt_v[0]), .sig_cycles(cyc_v[0]), .busy(busy_v[0]), .overrun(ovr_v[0]));

   out_signature_monitor #(.WINDOW(1), .SEED(32'h0000_0000)) u_z (
      .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .data_in(data_in),
      .sig_ready(sig_ready), .sig_valid(valid_v[1]), .sig_data(data_v[1]),
      .sig_count(cnt_v[1]), .sig_cycles(cyc_v[1]), .busy(busy_v[1]), .overrun(ovr_v[1]));

   out_signature_monitor #(.WINDOW(1), .SEED(32'h8000_0000)) u_f (
      .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .data_in(data_in),
      .sig_ready(sig_ready), .sig_valid(valid_v[2]), .sig_data(data_v[2]),
      .sig_count(cnt_v[2]), .sig_cycles(cyc_v[2]), .busy(busy_v[2]), .overrun(ovr_v[2]));

   out_signature_monitor #(.WINDOW(4)) u_g (
      .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .data_in(data_in),
      .sig_ready(sig_ready), .sig_valid(valid_v[3]), .sig_data(data_v[3]),
      .sig_count(cnt_v[3]), .sig_cycles(cyc_v[3]), .busy(busy_v[3]), .overrun(ovr_v[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference MISR: fold bit i of the bus onto signature bit i mod 32.
   function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [158:0] d);
      logic [31:0] f;
      logic [31:0] r;
      f = 32'h0;
      for (int i = 0; i < 159; i++) f[i % 32] = f[i % 32] ^ d[i];
      r = {s[30:0], 1'b0};
      if (s[31]) r = r ^ POLY_C;
      return r ^ f;
   endfunction

   task automatic lcg_data(output logic [158:0] d);
      logic [159:0] t;
      for (int j = 0; j < 5; j++) begin
         lcg_s = lcg_s * 32'd1664525 + 32'd1013904223;
         t[32*j +: 32] = lcg_s;
      end
      d = t[158:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0; sample_en = 1'b0; sig_ready = 1'b0; data_in = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_exp(input int inst, input logic [31:0] sig, input logic [15:0] cnt,
                           input logic [15:0] cyc);
      exp_t e;
      e.inst = inst; e.sig = sig; e.cnt = cnt; e.cyc = cyc;
      sb_q.push_back(e);
   endtask

   task automatic collect(input int inst);
      int   n;
      exp_t e;
      n = 0;
      while (!valid_v[inst] && n < 500) begin
         tick();
         n++;
      end
      check($sformatf("valid_seen_%0d", inst), 32'(valid_v[inst]), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("sb_inst",   32'(inst),          32'(e.inst));
         check("sig_data",  data_v[inst],       e.sig);
         check("sig_count", 32'(cnt_v[inst]),   32'(e.cnt));
         check("sig_cycles",32'(cyc_v[inst]),   32'(e.cyc));
      end
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      check("valid_after_accept", 32'(valid_v[inst]), 32'd0);
      check("busy_after_accept",  32'(busy_v[inst]),  32'd0);
   endtask

   task automatic one_shot(input int inst, input logic [158:0] d, input logic [31:0] exp_sig,
                           input string tag);
      do_reset();
      start_pulse();
      data_in = d;
      sample_en = 1'b1;
      push_exp(inst, exp_sig, 16'd1, 16'd1);
      tick();
      sample_en = 1'b0;
      check({tag, "_valid_at_M"}, 32'(valid_v[inst]), 32'd1);
      collect(inst);
   endtask

   task automatic run_def_window(output logic [31:0] s);
      logic [158:0] d;
      lcg_s = 32'd3199895932;
      start_pulse();
      s = SEED_DEF;
      for (int i = 0; i < 150; i++) begin
         lcg_data(d);
         data_in = d;
         sample_en = 1'b1;
         s = ref_step(s, d);
         if (i == 149) push_exp(0, s, 16'd150, 16'd150);
         tick();
         if (i == 148) check("def_valid_early", 32'(valid_v[0]), 32'd0);
      end
      sample_en = 1'b0;
      check("def_valid_at_M", 32'(valid_v[0]), 32'd1);
      collect(0);
   endtask

   initial begin
      logic [158:0] d;
      logic [31:0]  s, s_first, s_second;
      bit           pat[6];

      do_reset();
      check("rst_valid",   32'(valid_v[0]), 32'd0);
      check("rst_sig",     data_v[0],       SEED_DEF);
      check("rst_count",   32'(cnt_v[0]),   32'd0);
      check("rst_cycles",  32'(cyc_v[0]),   32'd0);
      check("rst_busy",    32'(busy_v[0]),  32'd0);
      check("rst_overrun", 32'(ovr_v[0]),   32'd0);

      // start with a same-cycle sample: not folded, busy rises at the start edge
      start = 1'b1; sample_en = 1'b1;
      tick();
      start = 1'b0; sample_en = 1'b0;
      check("busy_at_start", 32'(busy_v[1]), 32'd1);
      check("no_fold_at_start", 32'(cnt_v[1]), 32'd0);

      // WINDOW=1 single-sample windows
      one_shot(1, 159'd0, 32'h0000_0000, "zero");
      one_shot(2, 159'd0, 32'h04C1_1DB7, "feedback");
      d = '0; d[0] = 1'b1; d[32] = 1'b1;
      one_shot(1, d, 32'h0000_0000, "cancel");
      d = '0; d[158] = 1'b1;
      one_shot(1, d, 32'h4000_0000, "topbit");

      // gapped sampling on WINDOW=4
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      do_reset();
      lcg_s = 32'h1234_5678;
      start_pulse();
      s = SEED_DEF;
      for (int i = 0; i < 6; i++) begin
         lcg_data(d);
         data_in = d;
         sample_en = pat[i];
         if (pat[i]) s = ref_step(s, d);
         if (i == 5) push_exp(3, s, 16'd4, 16'd6);
         tick();
         if (i == 4) check("gap_not_hold_yet", 32'(valid_v[3]), 32'd0);
      end
      check("gap_hold_at_6", 32'(valid_v[3]), 32'd1);

      // backpressure with stray samples and a start pulse
      sample_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         lcg_data(d);
         data_in = d;
         tick();
         check("stall_sig",   data_v[3],          s);
         check("stall_valid", 32'(valid_v[3]),    32'd1);
      end
      start = 1'b0; sample_en = 1'b0;
      check("stall_overrun", 32'(ovr_v[3]), 32'd1);
      collect(3);
      check("overrun_in_idle", 32'(ovr_v[3]), 32'd1);
      check("sig_kept_in_idle", data_v[3], s);
      start_pulse();
      check("overrun_cleared", 32'(ovr_v[3]), 32'd0);
      check("busy_restart",    32'(busy_v[3]), 32'd1);

      // cross-check on default parameters
      do_reset();
      run_def_window(s_first);

      // reset abort after 3 samples
      do_reset();
      lcg_s = 32'd3199895932;
      start_pulse();
      for (int i = 0; i < 3; i++) begin
         lcg_data(d);
         data_in = d;
         sample_en = 1'b1;
         tick();
      end
      sample_en = 1'b0;
      check("abort_busy_before", 32'(busy_v[0]), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check("abort_valid",   32'(valid_v[0]), 32'd0);
      check("abort_sig",     data_v[0],       SEED_DEF);
      check("abort_count",   32'(cnt_v[0]),   32'd0);
      check("abort_cycles",  32'(cyc_v[0]),   32'd0);
      check("abort_busy",    32'(busy_v[0]),  32'd0);
      check("abort_overrun", 32'(ovr_v[0]),   32'd0);
      tick();
      rst = 1'b0;
      run_def_window(s_second);
      check("rerun_same_sig", s_second, s_first);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
